uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through a launch/ack drain FSM
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    uart_data,
    output logic          uart_en,
    input  logic          uart_rdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    state_t        state;

    // full/empty are registered, so a write while full is dropped even if a pop happens the same edge
    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty;

    // next occupancy from the accepted push and the drain pop
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // byte storage; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // write pointer, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    // drain FSM: launch one byte, wait for the UART to go busy, then wait for it to return ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            uart_en   <= 1'b0;
            uart_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        uart_data <= mem[rd_ptr];
                        uart_en   <= 1'b1;
                        rd_ptr    <= rd_ptr + AW'(1);
                        state     <= ACK;
                    end else begin
                        uart_en <= 1'b0;
                    end
                end
                ACK: begin
                    uart_en <= 1'b0;
                    if (!uart_rdy) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    uart_en <= 1'b0;
                    if (uart_rdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_en <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] uart_data;
    logic       uart_en;
    logic       uart_rdy;

    logic       man_rdy;
    logic       model_on;
    logic       model_rdy;
    int         frame_len;
    int         busy;

    int         errors;
    int         checks;
    logic [7:0] rx_q[$];
    int         launches;
    int         dbl_en;
    logic       prev_en;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .uart_data(uart_data),
        .uart_en(uart_en),
        .uart_rdy(uart_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign uart_rdy = model_on ? model_rdy : man_rdy;

    // UART transmitter model: goes busy on a launch, ready again after frame_len cycles
    always @(posedge clk) begin
        if (!model_on) begin
            model_rdy <= 1'b1;
            busy      <= 0;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) model_rdy <= 1'b1;
        end else if (uart_en) begin
            model_rdy <= 1'b0;
            busy      <= frame_len;
        end
    end

    // collect every launched byte and note any strobe wider than one cycle
    initial begin
        launches = 0;
        dbl_en   = 0;
        prev_en  = 1'b0;
    end
    always @(negedge clk) begin
        if (uart_en === 1'b1) begin
            rx_q.push_back(uart_data);
            launches = launches + 1;
            if (prev_en === 1'b1) dbl_en = dbl_en + 1;
        end
        prev_en = uart_en;
    end

    typedef struct {
        logic       r;
        logic       we;
        logic [7:0] d;
        logic       rdy;
        logic [4:0] cnt;
        logic       fl;
        logic       em;
        logic       ov;
        logic       en;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge: apply inputs for one edge, return at the following negedge
    task automatic cyc(input logic r, input logic w, input logic [7:0] d);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
    endtask

    int base;
    int t;
    int n;

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        man_rdy   = 1'b1;
        model_on  = 1'b0;
        frame_len = 20;

        //          rst we  d      rdy   cnt fl em ov en dat
        tbl[0]  = '{1, 0, 8'h00, 1, 5'd0, 0, 1, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 8'hA5, 1, 5'd1, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 1, 8'h5A, 1, 5'd1, 0, 0, 0, 1, 8'hA5};
        tbl[3]  = '{0, 0, 8'h00, 1, 5'd1, 0, 0, 0, 0, 8'hA5};
        tbl[4]  = '{0, 0, 8'h00, 1, 5'd1, 0, 0, 0, 0, 8'hA5};
        tbl[5]  = '{0, 0, 8'h00, 0, 5'd1, 0, 0, 0, 0, 8'hA5};
        tbl[6]  = '{0, 0, 8'h00, 0, 5'd1, 0, 0, 0, 0, 8'hA5};
        tbl[7]  = '{0, 0, 8'h00, 1, 5'd1, 0, 0, 0, 0, 8'hA5};
        tbl[8]  = '{0, 0, 8'h00, 1, 5'd0, 0, 1, 0, 1, 8'h5A};
        tbl[9]  = '{0, 0, 8'h00, 0, 5'd0, 0, 1, 0, 0, 8'h5A};
        tbl[10] = '{0, 0, 8'h00, 1, 5'd0, 0, 1, 0, 0, 8'h5A};
        tbl[11] = '{0, 0, 8'h00, 0, 5'd0, 0, 1, 0, 0, 8'h5A};
        tbl[12] = '{0, 1, 8'h11, 0, 5'd1, 0, 0, 0, 0, 8'h5A};
        tbl[13] = '{0, 1, 8'h22, 0, 5'd1, 0, 0, 0, 1, 8'h11};
        tbl[14] = '{0, 1, 8'h33, 0, 5'd2, 0, 0, 0, 0, 8'h11};
        tbl[15] = '{0, 1, 8'h44, 0, 5'd3, 0, 0, 0, 0, 8'h11};
        tbl[16] = '{1, 1, 8'h55, 1, 5'd0, 0, 1, 0, 0, 8'h00};
        tbl[17] = '{0, 1, 8'h3C, 1, 5'd1, 0, 0, 0, 0, 8'h00};
        tbl[18] = '{0, 0, 8'h00, 1, 5'd0, 0, 1, 0, 1, 8'h3C};
        tbl[19] = '{0, 0, 8'h00, 0, 5'd0, 0, 1, 0, 0, 8'h3C};
        tbl[20] = '{0, 0, 8'h00, 1, 5'd0, 0, 1, 0, 0, 8'h3C};

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            man_rdy = tbl[i].rdy;
            cyc(tbl[i].r, tbl[i].we, tbl[i].d);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].fl));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].em));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_uart_en", i), 32'(uart_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_uart_data", i), 32'(uart_data), 32'(tbl[i].dat));
        end

        // single byte through a full-length UART frame
        man_rdy = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        model_on  = 1'b1;
        frame_len = 10416;
        n = launches;
        cyc(1'b0, 1'b1, 8'hA5);
        chk("a5_count_after_write", 32'(count), 32'd1);
        chk("a5_en_after_write", 32'(uart_en), 32'd0);
        @(negedge clk);
        chk("a5_en_launch", 32'(uart_en), 32'd1);
        chk("a5_data_launch", 32'(uart_data), 32'hA5);
        @(negedge clk);
        chk("a5_en_one_cycle", 32'(uart_en), 32'd0);
        chk("a5_count_zero", 32'(count), 32'd0);
        for (t = 0; t < 20 && uart_rdy; t++) @(negedge clk);
        chk("a5_uart_busy", 32'(uart_rdy), 32'd0);
        for (t = 0; t < 12000 && !uart_rdy; t++) @(negedge clk);
        chk("a5_frame_done", 32'(uart_rdy), 32'd1);
        repeat (5) @(negedge clk);
        chk("a5_single_launch", 32'(launches - n), 32'd1);
        chk("a5_data_held", 32'(uart_data), 32'hA5);

        // burst of 16 behind a stuck launch, 17th write dropped
        model_on  = 1'b0;
        man_rdy   = 1'b1;
        frame_len = 20;
        cyc(1'b1, 1'b0, 8'h00);
        base = rx_q.size();
        cyc(1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(i));
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count16", 32'(count), 32'd16);
        chk("burst_no_ovf_yet", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1, 8'hFF);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_count_kept", 32'(count), 32'd16);
        man_rdy = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        model_on = 1'b1;
        for (t = 0; t < 1500 && !(rx_q.size() - base >= 17 && empty); t++) @(negedge clk);
        chk("burst_drained", 32'(rx_q.size() - base), 32'd17);
        if (rx_q.size() - base >= 17) begin
            chk("burst_rx_first", 32'(rx_q[base]), 32'hEE);
            for (int i = 0; i < 16; i++)
                chk($sformatf("burst_rx%0d", i), 32'(rx_q[base + 1 + i]), 32'(i));
        end
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);

        // write while full on the same edge as a pop
        model_on = 1'b0;
        man_rdy  = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i));
        chk("popfull_full", 32'(full), 32'd1);
        man_rdy = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        man_rdy = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hFF);
        chk("popfull_count15", 32'(count), 32'd15);
        chk("popfull_ovf", 32'(overflow), 32'd1);
        chk("popfull_not_full", 32'(full), 32'd0);
        chk("popfull_en", 32'(uart_en), 32'd1);
        chk("popfull_data", 32'(uart_data), 32'h10);

        // simultaneous write and pop at count 5, then mixed traffic across the pointer wrap
        cyc(1'b1, 1'b0, 8'h00);
        base = rx_q.size();
        cyc(1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i));
        chk("mix_count5", 32'(count), 32'd5);
        man_rdy = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        man_rdy = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h55);
        chk("mix_count_stays5", 32'(count), 32'd5);
        chk("mix_launch_data", 32'(uart_data), 32'h50);
        model_on  = 1'b1;
        frame_len = 4;
        for (int i = 0; i < 40; i++) cyc(1'b0, (i % 3) == 0, 8'(8'h60 + i));
        for (t = 0; t < 2000 && !(rx_q.size() - base >= 21 && empty); t++) @(negedge clk);
        chk("mix_drained", 32'(rx_q.size() - base), 32'd21);
        if (rx_q.size() - base >= 21) begin
            chk("mix_rx_first", 32'(rx_q[base]), 32'hEE);
            for (int i = 0; i < 6; i++)
                chk($sformatf("mix_rx5%0d", i), 32'(rx_q[base + 1 + i]), 32'(8'h50 + i));
            for (int j = 0; j < 14; j++)
                chk($sformatf("mix_rx_w%0d", j), 32'(rx_q[base + 7 + j]), 32'(8'h60 + 3 * j));
        end
        chk("mix_no_ovf", 32'(overflow), 32'd0);
        chk("mix_count0", 32'(count), 32'd0);
        chk("strobe_width", 32'(dbl_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
